// File: rtl/hbmc_rd_pkg.sv
// Shared constants and output-buffer entry layout for the HBMC read-data drain stage.
// Entry layout, MSB to LSB: {rresp, last, id, data}.
package hbmc_rd_pkg;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam int         OBUF_DEPTH   = 3;

    function automatic int obuf_id_lsb(input int dw);
        return dw;
    endfunction

    function automatic int obuf_last_bit(input int dw, input int iw);
        return dw + iw;
    endfunction

    function automatic int obuf_rresp_lsb(input int dw, input int iw);
        return dw + iw + 1;
    endfunction

    function automatic int obuf_entry_w(input int dw, input int iw);
        return dw + iw + 3;
    endfunction

    // Circular pointer advance for the 3-entry output buffer.
    function automatic logic [1:0] obuf_ptr_inc(input logic [1:0] ptr);
        logic [1:0] nxt;
        if (ptr == 2'(OBUF_DEPTH - 1)) begin
            nxt = 2'd0;
        end else begin
            nxt = ptr + 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/hbmc_rfifo_axi_rd_if.sv
// AXI4 R-channel bundle between the read-data drain stage and the AXI slave port.
interface hbmc_rfifo_axi_rd_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]   s_axi_rid;
    logic [DATA_WIDTH-1:0] s_axi_rdata;
    logic [1:0]            s_axi_rresp;
    logic                  s_axi_rlast;
    logic                  s_axi_rvalid;
    logic                  s_axi_rready;

    modport master (
        output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  s_axi_rready
    );

    modport slave (
        input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output s_axi_rready
    );
endinterface

// File: rtl/hbmc_rd_cmd_queue.sv
// Synchronous DEPTH-entry FIFO of accepted read-burst commands {id, len}.
// Full/empty come from a registered occupancy count.
module hbmc_rd_cmd_queue #(
    parameter int ID_WIDTH = 4,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                arstn,
    input  logic                push,
    input  logic [ID_WIDTH-1:0] push_id,
    input  logic [7:0]          push_len,
    input  logic                pop,
    output logic [ID_WIDTH-1:0] head_id,
    output logic [7:0]          head_len,
    output logic                full,
    output logic                empty
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]       wr_ptr_r;
    logic [PW-1:0]       rd_ptr_r;
    logic [PW:0]         count_r;
    logic [ID_WIDTH+7:0] mem_r [DEPTH];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= {push_id, push_len};
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head fields and status flags.
    always_comb begin
        head_id  = mem_r[rd_ptr_r][ID_WIDTH+7:8];
        head_len = mem_r[rd_ptr_r][7:0];
        full     = (count_r == (PW+1)'(DEPTH));
        empty    = (count_r == '0);
    end
endmodule

// File: rtl/hbmc_rfifo_axi_rd.sv
// Read-data drain: pops FIFO words and presents them as AXI4 R beats tagged from the command queue.
// Optional build macro HBMC_RD_LAST_CHECK_EN adds a FIFO-last cross-check and the rd_last_err port.
module hbmc_rfifo_axi_rd
    import hbmc_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int CMD_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [7:0]            cmd_len,
    input  logic [DATA_WIDTH-1:0] fifo_rd_dout,
    input  logic                  fifo_rd_last,
    input  logic                  fifo_rd_empty,
    output logic                  fifo_rd_ena,
    hbmc_rfifo_axi_rd_if.master   axi_r,
`ifdef HBMC_RD_LAST_CHECK_EN
    output logic                  rd_last_err,
`endif
    output logic                  rd_idle
);
    localparam int ID_LSB    = obuf_id_lsb(DATA_WIDTH);
    localparam int LAST_BIT  = obuf_last_bit(DATA_WIDTH, ID_WIDTH);
    localparam int RRESP_LSB = obuf_rresp_lsb(DATA_WIDTH, ID_WIDTH);
    localparam int EW        = obuf_entry_w(DATA_WIDTH, ID_WIDTH);

    if (!(DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_dw
        $error("hbmc_rfifo_axi_rd: DATA_WIDTH must be 16, 32 or 64");
    end
    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("hbmc_rfifo_axi_rd: CMD_DEPTH must be a power of 2 and >= 2");
    end

    logic                rdy_en_r;
    logic                q_push_s;
    logic                q_pop_s;
    logic                q_full_s;
    logic                q_empty_s;
    logic [ID_WIDTH-1:0] head_id_s;
    logic [7:0]          head_len_s;
    logic [2:0]          pend_s;
    logic                issue_s;
    logic [7:0]          beat_cnt_r;
    logic                inflight_r;
    logic                tag_last_r;
    logic [ID_WIDTH-1:0] tag_id_r;
    logic [1:0]          rresp_s;
    logic [EW-1:0]       entry_s;
    logic [EW-1:0]       head_s;
    logic [EW-1:0]       obuf_r [OBUF_DEPTH];
    logic [1:0]          wr_ptr_r;
    logic [1:0]          rd_ptr_r;
    logic [1:0]          occ_r;
    logic                obuf_pop_s;

    hbmc_rd_cmd_queue #(
        .ID_WIDTH (ID_WIDTH),
        .DEPTH    (CMD_DEPTH)
    ) u_cmd_queue (
        .clk      (clk),
        .arstn    (arstn),
        .push     (q_push_s),
        .push_id  (cmd_id),
        .push_len (cmd_len),
        .pop      (q_pop_s),
        .head_id  (head_id_s),
        .head_len (head_len_s),
        .full     (q_full_s),
        .empty    (q_empty_s)
    );

    // Holds cmd_ready low through reset and releases it on the first clock afterwards.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rdy_en_r <= 1'b0;
        end else begin
            rdy_en_r <= 1'b1;
        end
    end

    // Issue decision: only registered occupancy gates the FIFO read, never rready.
    always_comb begin
        pend_s = {1'b0, occ_r} + {2'b00, inflight_r};
        if (!fifo_rd_empty && !q_empty_s && (pend_s < 3'(OBUF_DEPTH))) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        if (issue_s && (beat_cnt_r == head_len_s)) begin
            q_pop_s = 1'b1;
        end else begin
            q_pop_s = 1'b0;
        end
        q_push_s    = cmd_valid & cmd_ready;
        cmd_ready   = rdy_en_r & ~q_full_s;
        fifo_rd_ena = issue_s;
    end

    // Beat counter within the head burst and the tag of the read in flight.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            beat_cnt_r <= 8'd0;
            inflight_r <= 1'b0;
            tag_last_r <= 1'b0;
            tag_id_r   <= '0;
        end else begin
            if (q_pop_s) begin
                beat_cnt_r <= 8'd0;
            end else if (issue_s) begin
                beat_cnt_r <= beat_cnt_r + 8'd1;
            end
            inflight_r <= issue_s;
            if (issue_s) begin
                tag_id_r   <= head_id_s;
                tag_last_r <= q_pop_s;
            end
        end
    end

    // Captured entry; RLAST always follows the counted tag.
    always_comb begin
`ifdef HBMC_RD_LAST_CHECK_EN
        if (tag_last_r != fifo_rd_last) begin
            rresp_s = RRESP_SLVERR;
        end else begin
            rresp_s = RRESP_OKAY;
        end
`else
        rresp_s = RRESP_OKAY;
`endif
        entry_s = {rresp_s, tag_last_r, tag_id_r, fifo_rd_dout};
    end

`ifdef HBMC_RD_LAST_CHECK_EN
    // Sticky flag for a FIFO last tag disagreeing with the counted burst position.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rd_last_err <= 1'b0;
        end else if (inflight_r && (tag_last_r != fifo_rd_last)) begin
            rd_last_err <= 1'b1;
        end
    end
`else
    logic fifo_last_unused_s;
    assign fifo_last_unused_s = fifo_rd_last;
`endif

    // Three-entry circular output buffer; its head drives the R channel.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                obuf_r[i] <= '0;
            end
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            occ_r    <= 2'd0;
        end else begin
            if (inflight_r) begin
                obuf_r[wr_ptr_r] <= entry_s;
                wr_ptr_r         <= obuf_ptr_inc(wr_ptr_r);
            end
            if (obuf_pop_s) begin
                rd_ptr_r <= obuf_ptr_inc(rd_ptr_r);
            end
            case ({inflight_r, obuf_pop_s})
                2'b10:   occ_r <= occ_r + 2'd1;
                2'b01:   occ_r <= occ_r - 2'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // R-channel outputs straight from buffer registers.
    always_comb begin
        head_s             = obuf_r[rd_ptr_r];
        axi_r.s_axi_rvalid = (occ_r != 2'd0);
        axi_r.s_axi_rdata  = head_s[DATA_WIDTH-1:0];
        axi_r.s_axi_rid    = head_s[ID_LSB +: ID_WIDTH];
        axi_r.s_axi_rlast  = head_s[LAST_BIT];
        axi_r.s_axi_rresp  = head_s[RRESP_LSB +: 2];
        obuf_pop_s         = (occ_r != 2'd0) && axi_r.s_axi_rready;
        rd_idle            = q_empty_s && !inflight_r && (occ_r == 2'd0);
    end
endmodule

// File: tb/tb_hbmc_rfifo_axi_rd.sv
// Self-checking bench for hbmc_rfifo_axi_rd: behavioural FIFO, burst-expansion reference and R monitor.
// Build with +define+HBMC_RD_LAST_CHECK_EN to cover the last-tag check.
module tb_hbmc_rfifo_axi_rd;
    localparam int DW = 32;
    localparam int IW = 4;
`ifdef HBMC_RD_LAST_CHECK_EN
    localparam bit LAST_CHK = 1'b1;
`else
    localparam bit LAST_CHK = 1'b0;
`endif

    typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; logic last; logic [1:0] resp; int cyc; } beat_t;
    typedef struct { logic [IW-1:0] id; logic [7:0] len; } cmd_t;
    typedef struct { logic [IW-1:0] id; logic last; } tag_t;

    logic          clk = 1'b0;
    logic          arstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [IW-1:0] cmd_id = '0;
    logic [7:0]    cmd_len = 8'd0;
    logic [DW-1:0] fifo_rd_dout = '0;
    logic          fifo_rd_last = 1'b0;
    logic          fifo_rd_empty = 1'b1;
    logic          fifo_rd_ena;
    logic          rd_idle;
`ifdef HBMC_RD_LAST_CHECK_EN
    logic          rd_last_err;
`endif

    hbmc_rfifo_axi_rd_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) rif ();

    hbmc_rfifo_axi_rd #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .CMD_DEPTH(4)) dut (
        .clk           (clk),
        .arstn         (arstn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_id        (cmd_id),
        .cmd_len       (cmd_len),
        .fifo_rd_dout  (fifo_rd_dout),
        .fifo_rd_last  (fifo_rd_last),
        .fifo_rd_empty (fifo_rd_empty),
        .fifo_rd_ena   (fifo_rd_ena),
        .axi_r         (rif.master),
`ifdef HBMC_RD_LAST_CHECK_EN
        .rd_last_err   (rd_last_err),
`endif
        .rd_idle       (rd_idle)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] fq_data [$];
    logic          fq_last [$];
    cmd_t          cq [$];
    tag_t          tagq [$];
    beat_t         exp_q [$];
    beat_t         obs [$];
    int            words_added = 0;
    int            cmd_beats = 0;
    int            issued = 0;
    int            accepted = 0;
    int            issue_viol = 0;
    int            stab_viol = 0;
    int            max_pend = 0;
    int            cyc = 0;
    int            first_ena = -1;
    int            first_rv = -1;
    int            gap_start = 4;
    bit            held_valid = 1'b0;
    beat_t         held;

    // Reference: each command expands into len+1 tags; tags pair with FIFO words in order.
    task automatic add_cmd(input logic [IW-1:0] id, input logic [7:0] len);
        cmd_t c;
        tag_t t;
        c.id = id;
        c.len = len;
        cq.push_back(c);
        for (int j = 0; j <= int'(len); j++) begin
            t.id = id;
            t.last = (j == int'(len));
            tagq.push_back(t);
        end
    endtask

    task automatic add_words(input int n, input bit use_base, input logic [DW-1:0] base, input int flip);
        beat_t e;
        tag_t  t;
        for (int i = 0; i < n; i++) begin
            t = tagq[words_added];
            e.data = use_base ? (base + DW'(i)) : DW'($urandom);
            e.id = t.id;
            e.last = t.last;
            e.resp = ((i == flip) && LAST_CHK) ? 2'b10 : 2'b00;
            e.cyc = 0;
            fq_data.push_back(e.data);
            fq_last.push_back(t.last ^ (i == flip));
            exp_q.push_back(e);
            words_added++;
        end
    endtask

    // One clock: drive inputs at negedge, observe just before posedge, model the FIFO after it.
    task automatic tick(input logic rr, input logic gate);
        logic  ena;
        logic  hs;
        logic  cmd_acc;
        beat_t b;
        @(negedge clk);
        rif.s_axi_rready = rr;
        fifo_rd_empty = gate || (fq_data.size() == 0);
        if (cq.size() != 0) begin
            cmd_valid = 1'b1;
            cmd_id = cq[0].id;
            cmd_len = cq[0].len;
        end else begin
            cmd_valid = 1'b0;
        end
        #1;
        ena = fifo_rd_ena;
        if (ena !== (!fifo_rd_empty && (cmd_beats > issued) && (issued - accepted < 3))) issue_viol++;
        if (issued - accepted > max_pend) max_pend = issued - accepted;
        if (held_valid && (rif.s_axi_rvalid !== 1'b1 || rif.s_axi_rid !== held.id ||
            rif.s_axi_rdata !== held.data || rif.s_axi_rlast !== held.last || rif.s_axi_rresp !== held.resp))
            stab_viol++;
        if (rif.s_axi_rvalid === 1'b1 && first_rv < 0) first_rv = cyc;
        if (ena === 1'b1 && first_ena < 0) first_ena = cyc;
        hs = (rif.s_axi_rvalid === 1'b1) && rr;
        b.id = rif.s_axi_rid;
        b.data = rif.s_axi_rdata;
        b.last = rif.s_axi_rlast;
        b.resp = rif.s_axi_rresp;
        b.cyc = cyc;
        held_valid = (rif.s_axi_rvalid === 1'b1) && !rr;
        held = b;
        cmd_acc = cmd_valid && (cmd_ready === 1'b1);
        @(posedge clk);
        #1;
        if (ena === 1'b1 && fq_data.size() != 0) begin
            fifo_rd_dout = fq_data.pop_front();
            fifo_rd_last = fq_last.pop_front();
            issued++;
        end
        if (cmd_acc) begin
            cmd_beats += int'(cq[0].len) + 1;
            cq.delete(0);
        end
        if (hs) begin
            obs.push_back(b);
            accepted++;
        end
        cyc++;
    endtask

    task automatic run(input int mode, input int budget);
        logic [3:0] pat;
        int n;
        pat = 4'b1001;
        n = 0;
        while (obs.size() < exp_q.size() && n < budget) begin
            case (mode)
                0:       tick(1'b1, 1'b0);
                1:       tick(pat[n % 4], 1'b0);
                2:       tick(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
                3:       tick(1'b1, (n >= gap_start) && (n < gap_start + 5));
                default: tick(1'b1, 1'b0);
            endcase
            n++;
        end
    endtask

    task automatic new_test();
        obs.delete();
        exp_q.delete();
        first_ena = -1;
        first_rv = -1;
        max_pend = 0;
        issue_viol = 0;
        stab_viol = 0;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({cmd_ready, fifo_rd_ena, rif.s_axi_rvalid, rif.s_axi_rlast, rd_idle} !== 5'b00001) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00001", {cmd_ready, fifo_rd_ena, rif.s_axi_rvalid, rif.s_axi_rlast, rd_idle});
        end
        total++;
        if ({rif.s_axi_rresp, rif.s_axi_rid, rif.s_axi_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_fields: got rresp=%0h rid=%0h rdata=%0h want 0", rif.s_axi_rresp, rif.s_axi_rid, rif.s_axi_rdata);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold_ready: got %b want 0", cmd_ready);
        end
        @(negedge clk);
        arstn = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({cmd_ready, rd_idle} !== 2'b11) begin
            bad++;
            $display("FAIL release_ready_idle: got %b want 11", {cmd_ready, rd_idle});
        end
    endtask

    task automatic test_single_burst();
        new_test();
        add_cmd(4'd3, 8'd3);
        add_words(4, 1'b1, 32'hA0, -1);
        run(0, 50);
        total++;
        if (obs.size() != 4) begin
            bad++;
            $display("FAIL single_count: got %0d want 4", obs.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            total++;
            if ({obs[i].id, obs[i].data, obs[i].last, obs[i].resp} !== {exp_q[i].id, exp_q[i].data, exp_q[i].last, exp_q[i].resp}) begin
                bad++;
                $display("FAIL single_beat%0d: got id=%0h d=%0h l=%b r=%0h want id=%0h d=%0h l=%b r=%0h", i,
                         obs[i].id, obs[i].data, obs[i].last, obs[i].resp, exp_q[i].id, exp_q[i].data, exp_q[i].last, exp_q[i].resp);
            end
        end
        total++;
        if (obs.size() == 4 && (obs[3].cyc - obs[0].cyc) != 3) begin
            bad++;
            $display("FAIL single_span: got %0d want 3", obs[3].cyc - obs[0].cyc);
        end
        total++;
        if (first_rv - first_ena != 2) begin
            bad++;
            $display("FAIL single_latency: got %0d want 2", first_rv - first_ena);
        end
        total++;
        if ({issue_viol, rd_idle} != {32'd0, 1'b1}) begin
            bad++;
            $display("FAIL single_issue_idle: got viol=%0d idle=%b want 0 1", issue_viol, rd_idle);
        end
    endtask

    task automatic test_back_to_back();
        new_test();
        add_cmd(4'd1, 8'd0);
        add_cmd(4'd2, 8'd1);
        add_words(3, 1'b1, 32'hB0, -1);
        run(0, 50);
        total++;
        if (obs.size() != 3) begin
            bad++;
            $display("FAIL b2b_count: got %0d want 3", obs.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            total++;
            if ({obs[i].id, obs[i].data, obs[i].last, obs[i].resp, obs[i].cyc - obs[0].cyc} !==
                {exp_q[i].id, exp_q[i].data, exp_q[i].last, exp_q[i].resp, i}) begin
                bad++;
                $display("FAIL b2b_beat%0d: got id=%0h d=%0h l=%b off=%0d want id=%0h d=%0h l=%b off=%0d", i,
                         obs[i].id, obs[i].data, obs[i].last, obs[i].cyc - obs[0].cyc, exp_q[i].id, exp_q[i].data, exp_q[i].last, i);
            end
        end
    endtask

    task automatic test_rready_stall();
        new_test();
        add_cmd(4'd7, 8'd7);
        add_words(8, 1'b0, '0, -1);
        run(1, 200);
        total++;
        if (obs.size() != 8) begin
            bad++;
            $display("FAIL stall_count: got %0d want 8", obs.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            total++;
            if ({obs[i].id, obs[i].data, obs[i].last} !== {exp_q[i].id, exp_q[i].data, exp_q[i].last}) begin
                bad++;
                $display("FAIL stall_beat%0d: got id=%0h d=%0h l=%b want id=%0h d=%0h l=%b", i,
                         obs[i].id, obs[i].data, obs[i].last, exp_q[i].id, exp_q[i].data, exp_q[i].last);
            end
        end
        total++;
        if ({issue_viol, stab_viol, max_pend} != {32'd0, 32'd0, 32'd3}) begin
            bad++;
            $display("FAIL stall_flow: got issue_viol=%0d stab_viol=%0d max_pend=%0d want 0 0 3", issue_viol, stab_viol, max_pend);
        end
    endtask

    task automatic test_fifo_gap();
        new_test();
        gap_start = 4;
        add_cmd(4'd9, 8'd7);
        add_words(8, 1'b1, 32'hD0, -1);
        run(3, 200);
        total++;
        if (obs.size() != 8) begin
            bad++;
            $display("FAIL gap_count: got %0d want 8", obs.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            total++;
            if ({obs[i].id, obs[i].data, obs[i].last} !== {exp_q[i].id, exp_q[i].data, exp_q[i].last}) begin
                bad++;
                $display("FAIL gap_beat%0d: got id=%0h d=%0h l=%b want id=%0h d=%0h l=%b", i,
                         obs[i].id, obs[i].data, obs[i].last, exp_q[i].id, exp_q[i].data, exp_q[i].last);
            end
        end
        total++;
        if (obs.size() == 8 && (obs[7].cyc - obs[0].cyc) <= 7) begin
            bad++;
            $display("FAIL gap_bubble: got span %0d want >7", obs[7].cyc - obs[0].cyc);
        end
        total++;
        if (issue_viol != 0) begin
            bad++;
            $display("FAIL gap_issue: got %0d want 0", issue_viol);
        end
    endtask

    task automatic test_random();
        logic [7:0] len;
        new_test();
        for (int k = 0; k < 6; k++) begin
            len = (k == 2) ? 8'd255 : 8'($urandom_range(0, 12));
            add_cmd(IW'($urandom_range(0, 15)), len);
            add_words(int'(len) + 1, 1'b0, '0, -1);
        end
        run(2, 4000);
        total++;
        if (obs.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rand_count: got %0d want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            total++;
            if ({obs[i].id, obs[i].data, obs[i].last, obs[i].resp} !== {exp_q[i].id, exp_q[i].data, exp_q[i].last, exp_q[i].resp}) begin
                bad++;
                $display("FAIL rand_beat%0d: got id=%0h d=%0h l=%b r=%0h want id=%0h d=%0h l=%b r=%0h", i,
                         obs[i].id, obs[i].data, obs[i].last, obs[i].resp, exp_q[i].id, exp_q[i].data, exp_q[i].last, exp_q[i].resp);
            end
        end
        total++;
        if ({issue_viol, stab_viol, 31'd0, rd_idle} != {32'd0, 32'd0, 32'd1}) begin
            bad++;
            $display("FAIL rand_flow: got issue_viol=%0d stab_viol=%0d idle=%b want 0 0 1", issue_viol, stab_viol, rd_idle);
        end
    endtask

    task automatic test_last_check();
        new_test();
`ifdef HBMC_RD_LAST_CHECK_EN
        total++;
        if (rd_last_err !== 1'b0) begin
            bad++;
            $display("FAIL lastchk_pre: got %b want 0", rd_last_err);
        end
`endif
        add_cmd(4'd4, 8'd3);
        add_words(4, 1'b1, 32'hC0, 1);
        add_cmd(4'd2, 8'd1);
        add_words(2, 1'b1, 32'hE0, -1);
        run(0, 100);
        total++;
        if (obs.size() != 6) begin
            bad++;
            $display("FAIL lastchk_count: got %0d want 6", obs.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            total++;
            if ({obs[i].id, obs[i].data, obs[i].last, obs[i].resp} !== {exp_q[i].id, exp_q[i].data, exp_q[i].last, exp_q[i].resp}) begin
                bad++;
                $display("FAIL lastchk_beat%0d: got id=%0h d=%0h l=%b r=%0h want id=%0h d=%0h l=%b r=%0h", i,
                         obs[i].id, obs[i].data, obs[i].last, obs[i].resp, exp_q[i].id, exp_q[i].data, exp_q[i].last, exp_q[i].resp);
            end
        end
`ifdef HBMC_RD_LAST_CHECK_EN
        total++;
        if (rd_last_err !== 1'b1) begin
            bad++;
            $display("FAIL lastchk_sticky: got %b want 1", rd_last_err);
        end
`endif
    endtask

    task automatic test_reset_mid_burst();
        int n;
        new_test();
        add_cmd(4'd5, 8'd7);
        add_words(8, 1'b0, '0, -1);
        n = 0;
        while (rif.s_axi_rvalid !== 1'b1 && n < 20) begin
            tick(1'b0, 1'b0);
            n++;
        end
        tick(1'b0, 1'b0);
        arstn = 1'b0;
        #1;
        total++;
        if ({rif.s_axi_rvalid, rd_idle, cmd_ready, fifo_rd_ena} !== 4'b0100) begin
            bad++;
            $display("FAIL midrst_async: got valid/idle/ready/ena=%b want 0100", {rif.s_axi_rvalid, rd_idle, cmd_ready, fifo_rd_ena});
        end
`ifdef HBMC_RD_LAST_CHECK_EN
        total++;
        if (rd_last_err !== 1'b0) begin
            bad++;
            $display("FAIL midrst_err_clear: got %b want 0", rd_last_err);
        end
`endif
        fq_data.delete();
        fq_last.delete();
        cq.delete();
        tagq.delete();
        new_test();
        words_added = 0;
        cmd_beats = 0;
        issued = 0;
        accepted = 0;
        held_valid = 1'b0;
        cmd_valid = 1'b0;
        fifo_rd_empty = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        arstn = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({cmd_ready, rd_idle, rif.s_axi_rvalid} !== 3'b110) begin
            bad++;
            $display("FAIL midrst_release: got ready/idle/valid=%b want 110", {cmd_ready, rd_idle, rif.s_axi_rvalid});
        end
        add_cmd(4'd6, 8'd1);
        add_words(2, 1'b1, 32'hF0, -1);
        run(0, 50);
        total++;
        if (obs.size() != 2 || obs[0].data !== 32'hF0 || obs[1].last !== 1'b1 || obs[0].id !== 4'd6) begin
            bad++;
            $display("FAIL midrst_recover: got %0d beats, first data %0h want 2 beats starting f0", obs.size(),
                     (obs.size() != 0) ? obs[0].data : 32'h0);
        end
    endtask

    initial begin
        rif.s_axi_rready = 1'b0;
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_rready_stall();
        test_fifo_gap();
        test_random();
        test_last_check();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/hbmc_rfifo_axi_rd.md
Name: hbmc_rfifo_axi_rd

Overview:
Drain stage directly downstream of the read-data FIFO, in the AXI clock domain. Pops memory read words from the FIFO read port and presents them as AXI4 R-channel beats. Generates RID/RLAST from a queue of accepted read-burst commands (id, len) and applies R-channel back-pressure through a 3-entry output buffer.

Parameters:
DATA_WIDTH, 32, FIFO read word and RDATA width; legal values 16/32/64, anything else is an elaboration error.
ID_WIDTH, 4, AXI ID width.
CMD_DEPTH, 4, read-command queue depth; power of 2, >= 2.

Ports:
clk  in  1  AXI/FIFO read-side clock.
arstn  in  1  asynchronous active-low reset.
cmd_valid  in  1  read-burst command valid (from AR decoder).
cmd_ready  out  1  command queue not full.
cmd_id  in  ID_WIDTH  burst ARID.
cmd_len  in  8  ARLEN (beats-1).
fifo_rd_dout  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_ena.
fifo_rd_last  in  1  FIFO last-word tag, aligned with fifo_rd_dout.
fifo_rd_empty  in  1  FIFO empty.
fifo_rd_ena  out  1  FIFO read strobe.
s_axi_rid  out  ID_WIDTH  RID.
s_axi_rdata  out  DATA_WIDTH  RDATA.
s_axi_rresp  out  2  RRESP.
s_axi_rlast  out  1  RLAST.
s_axi_rvalid  out  1  RVALID.
s_axi_rready  in  1  RREADY.
rd_idle  out  1  queue empty, nothing in flight, buffer empty.

Behaviour:
- Reset (async, arstn=0): command queue and output buffer emptied; all counters 0.
- Outputs during reset: cmd_ready=0, fifo_rd_ena=0, s_axi_rvalid=0, s_axi_rlast=0, s_axi_rresp=0, s_axi_rid=0, s_axi_rdata=0, rd_idle=1.
- Reset asserted mid-burst drops everything. Remaining FIFO contents are not this block's concern; the FIFO shares the reset.
- Command accept: cmd_valid & cmd_ready pushes {id,len}.
- Simultaneous push and pop on a full queue is not allowed; cmd_ready is derived from registered count only.
- Issue: fifo_rd_ena = !fifo_rd_empty & queue non-empty & (occ + inflight < 3).
  - occ = buffer entries; inflight = reads issued last cycle.
  - No combinational path from s_axi_rready to fifo_rd_ena.
- Issue beat counter 0..cmd_len. Each issued read tags {head id, last = (cnt==len)}.
  - On last, pop head and reset the counter. The next command may issue in the following cycle.
- Capture: cycle N fifo_rd_ena -> cycle N+1 fifo_rd_dout/last written to buffer with tag -> cycle N+2 s_axi_rvalid=1. Minimum latency 2 cycles.
- With RREADY held high and the FIFO non-empty: sustained 1 beat/cycle, no bubbles, including across burst boundaries.
- Output buffer: 3-entry circular FIFO; head drives the R signals; pop on rvalid & rready.
- AXI rule: once rvalid=1, rid/rdata/rlast/rresp stay stable until the handshake completes.
- cmd_len=0: single beat with rlast=1. cmd_len=255: 256 beats; counter is 8 bits with no wrap.
- FIFO goes empty mid-burst: issue stalls; already buffered beats still drain.
- s_axi_rresp=2'b00 (OKAY) unless the optional feature below says otherwise.

Optional Feature:
Macro HBMC_RD_LAST_CHECK_EN.
- Defined: on capture, the counted last tag is compared with fifo_rd_last.
  - Mismatch marks that beat RRESP=2'b10 (SLVERR).
  - Mismatch also sets sticky output rd_last_err (extra port, 1 bit, reset 0, cleared only by reset).
  - RLAST still follows the counted tag.
- Undefined: fifo_rd_last is ignored, RRESP is constant OKAY, and the rd_last_err port is absent.

Decomposition:
- Package hbmc_rd_pkg holds:
  - RRESP_OKAY = 2'b00 and RRESP_SLVERR = 2'b10;
  - OBUF_DEPTH = 3;
  - the buffer-entry field layout {rresp, last, id, data}.
- One sub-module: hbmc_rd_cmd_queue, a synchronous CMD_DEPTH-entry FIFO for {id,len} with count-based full/empty.

Test Plan:
- Reset with rvalid=1 mid-burst -> rvalid drops to 0 asynchronously; rd_idle=1; cmd_ready=1 on the first clk after release.
- cmd id=3 len=3, FIFO preloaded with 4 words 0xA0..0xA3, rready=1:
  - 4 beats on consecutive cycles, rid=3, rlast only on 0xA3;
  - first rvalid exactly 2 cycles after first fifo_rd_ena.
- Back-to-back cmds (id1 len0, id2 len1), FIFO full, rready=1 -> beats id1/last, id2, id2/last with no idle cycle.
- rready toggling 1-0-0-1 during a len=7 burst:
  - fifo_rd_ena deasserts when occ+inflight=3;
  - no beat lost or duplicated; rdata stable while stalled.
- FIFO empty for 5 cycles mid-burst -> rvalid gaps; rid and beat order preserved.
- With HBMC_RD_LAST_CHECK_EN: fifo_rd_last=1 on beat 1 of a len=3 burst -> beat 1 RRESP=SLVERR; rd_last_err=1 and stays set; rlast still only on beat 3.
